uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default parameter constants
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_RATE  = 115200;
  localparam int UART_CLK_FREQ   = 200_000_000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for an asynchronous idle-high line
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the raw input one stage per clock
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // stages reset to 1 so a reset never looks like a falling edge on an idle line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with valid/ready word output and error pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BAUD_RATE  = UART_BAUD_RATE,
  parameter int CLK_FREQ   = UART_CLK_FREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic sig_s;

  uart_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig),
    .q   (sig_s)
  );

  uart_rx_state_t        state_q,     state_d;
  logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  valid_q,     valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q,   overrun_d;
  logic                  sig_prev_q,  sig_prev_d;

  // next-state: frame sequencing, word delivery and consumer handshake
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    sig_prev_d  = sig_s;

    // a handshake frees the output slot; a same-cycle delivery below refills it
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sig_prev_q && !sig_s) begin
          state_d   = START;
          clk_cnt_d = CNT_HALF;
        end
      end
      START: begin
        if (clk_cnt_q == '0) begin
          if (!sig_s) begin
            state_d   = DATA;
            clk_cnt_d = CNT_FULL;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == '0) begin
          shreg_d   = {sig_s, shreg_q[DATA_WIDTH-1:1]};
          clk_cnt_d = CNT_FULL;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == '0) begin
          if (sig_s) begin
            state_d = IDLE;
            if (!valid_q || ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = RECOVER;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        // a line held low after a bad stop bit must not be read as a new start
        if (sig_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // register all state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      sig_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      sig_prev_q  <= sig_prev_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
